nv_nvdla_cdp_dp_lut_rd: RTL and testbench

LUT read stage of the CDP datapath, sitting on the receiving end of the `dp2lut` interface driven by the CDP LUT control block. For each lane it takes the X (LE table) and Y (LO table) entry indices and their info words, then reads adjacent entry pairs from the LE and LO tables. It forwards the pairs with the info words to the interpolator on `lut2intp` using valid/ready flow control. It also holds the register-programmed table storage and saturating underflow/overflow statistics counters.

---
 rtl/nv_nvdla_cdp_dp_lut_rd.sv | 177 +++++++++++++++++
 tb/tb_nv_nvdla_cdp_dp_lut_rd.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cdp_dp_lut_rd.sv
// CDP LUT read stage: clamps per-lane LE/LO indices, reads adjacent entry pairs
// into a single skid-free output register, and keeps saturating flow statistics.
module nv_nvdla_cdp_dp_lut_rd #(
  parameter int TP       = 4,
  parameter int LE_DEPTH = 65,
  parameter int LO_DEPTH = 257,
  parameter int DATA_W   = 16
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 dp2lut_pvld,
  output logic                 dp2lut_prdy,
  input  logic [TP*10-1:0]     dp2lut_X_entry,
  input  logic [TP*18-1:0]     dp2lut_Xinfo,
  input  logic [TP*10-1:0]     dp2lut_Y_entry,
  input  logic [TP*18-1:0]     dp2lut_Yinfo,
  output logic                 lut2intp_pvld,
  input  logic                 lut2intp_prdy,
  output logic [TP*DATA_W-1:0] lut2intp_X_data0,
  output logic [TP*DATA_W-1:0] lut2intp_X_data1,
  output logic [TP*DATA_W-1:0] lut2intp_Y_data0,
  output logic [TP*DATA_W-1:0] lut2intp_Y_data1,
  output logic [TP*18-1:0]     lut2intp_Xinfo,
  output logic [TP*18-1:0]     lut2intp_Yinfo,
  input  logic                 lut_wr_en,
  input  logic                 lut_wr_table,
  input  logic [8:0]           lut_wr_addr,
  input  logic [DATA_W-1:0]    lut_wr_data,
  input  logic                 op_en_start,
  output logic [31:0]          le_uflow_cnt,
  output logic [31:0]          le_oflow_cnt,
  output logic [31:0]          lo_uflow_cnt,
  output logic [31:0]          lo_oflow_cnt
);

  localparam int LE_AW = $clog2(LE_DEPTH);
  localparam int LO_AW = $clog2(LO_DEPTH);
  localparam int NW    = $clog2(TP + 1);
  localparam logic [9:0]       LE_LAST_E = 10'(LE_DEPTH - 1);
  localparam logic [9:0]       LO_LAST_E = 10'(LO_DEPTH - 1);
  localparam logic [8:0]       LE_LAST_A = 9'(LE_DEPTH - 1);
  localparam logic [8:0]       LO_LAST_A = 9'(LO_DEPTH - 1);
  localparam logic [LE_AW-1:0] LE_LAST   = LE_AW'(LE_DEPTH - 1);
  localparam logic [LO_AW-1:0] LO_LAST   = LO_AW'(LO_DEPTH - 1);

  logic [DATA_W-1:0] le_tbl_q [LE_DEPTH];
  logic [DATA_W-1:0] lo_tbl_q [LO_DEPTH];

  logic                 acc;
  logic                 le_we, lo_we;
  logic                 vld_p1_d, vld_p1_q;
  logic [TP*DATA_W-1:0] x_data0_p1_d, x_data0_p1_q, x_data1_p1_d, x_data1_p1_q;
  logic [TP*DATA_W-1:0] y_data0_p1_d, y_data0_p1_q, y_data1_p1_d, y_data1_p1_q;
  logic [TP*18-1:0]     xinfo_p1_d, xinfo_p1_q, yinfo_p1_d, yinfo_p1_q;
  logic [31:0]          le_uflow_cnt_d, le_uflow_cnt_q, le_oflow_cnt_d, le_oflow_cnt_q;
  logic [31:0]          lo_uflow_cnt_d, lo_uflow_cnt_q, lo_oflow_cnt_d, lo_oflow_cnt_q;

  function automatic logic [LE_AW-1:0] le_idx(input logic [9:0] e);
    return (e > LE_LAST_E) ? LE_LAST : e[LE_AW-1:0];
  endfunction

  function automatic logic [LE_AW-1:0] le_nxt(input logic [LE_AW-1:0] i);
    return (i == LE_LAST) ? i : i + LE_AW'(1);
  endfunction

  function automatic logic [LO_AW-1:0] lo_idx(input logic [9:0] e);
    return (e > LO_LAST_E) ? LO_LAST : e[LO_AW-1:0];
  endfunction

  function automatic logic [LO_AW-1:0] lo_nxt(input logic [LO_AW-1:0] i);
    return (i == LO_LAST) ? i : i + LO_AW'(1);
  endfunction

  function automatic logic [NW-1:0] lane_cnt(input logic [TP*18-1:0] info, input int bitpos);
    logic [NW-1:0] n;
    n = '0;
    for (int m = 0; m < TP; m++) n = n + NW'(info[18*m+bitpos]);
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [NW-1:0] inc);
    logic [32:0] s;
    s = {1'b0, base} + 33'(inc);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Start-of-layer clear happens first, so a coincident beat counts from zero.
  function automatic logic [31:0] cnt_next(input logic [31:0] q, input logic clr,
                                           input logic hit, input logic [NW-1:0] inc);
    logic [31:0] base;
    base = clr ? 32'h0 : q;
    return hit ? sat_add(base, inc) : base;
  endfunction

  assign dp2lut_prdy = ~vld_p1_q | lut2intp_prdy;
  assign acc         = dp2lut_pvld & dp2lut_prdy;
  assign le_we       = lut_wr_en & ~lut_wr_table & (lut_wr_addr <= LE_LAST_A);
  assign lo_we       = lut_wr_en &  lut_wr_table & (lut_wr_addr <= LO_LAST_A);

  // Table storage: no reset; nonblocking write keeps same-cycle reads on old data.
  always_ff @(posedge nvdla_core_clk) begin
    if (le_we) le_tbl_q[lut_wr_addr[LE_AW-1:0]] <= lut_wr_data;
    if (lo_we) lo_tbl_q[lut_wr_addr[LO_AW-1:0]] <= lut_wr_data;
  end

  // p0 -> p1: clamp, pair read and output register
  always_comb begin
    vld_p1_d     = vld_p1_q;
    x_data0_p1_d = x_data0_p1_q;
    x_data1_p1_d = x_data1_p1_q;
    y_data0_p1_d = y_data0_p1_q;
    y_data1_p1_d = y_data1_p1_q;
    xinfo_p1_d   = xinfo_p1_q;
    yinfo_p1_d   = yinfo_p1_q;
    if (acc) begin
      vld_p1_d   = 1'b1;
      xinfo_p1_d = dp2lut_Xinfo;
      yinfo_p1_d = dp2lut_Yinfo;
      for (int m = 0; m < TP; m++) begin
        x_data0_p1_d[DATA_W*m +: DATA_W] = le_tbl_q[le_idx(dp2lut_X_entry[10*m +: 10])];
        x_data1_p1_d[DATA_W*m +: DATA_W] = le_tbl_q[le_nxt(le_idx(dp2lut_X_entry[10*m +: 10]))];
        y_data0_p1_d[DATA_W*m +: DATA_W] = lo_tbl_q[lo_idx(dp2lut_Y_entry[10*m +: 10])];
        y_data1_p1_d[DATA_W*m +: DATA_W] = lo_tbl_q[lo_nxt(lo_idx(dp2lut_Y_entry[10*m +: 10]))];
      end
    end else if (lut2intp_prdy) begin
      vld_p1_d = 1'b0;
    end
  end

  always_comb begin
    le_uflow_cnt_d = cnt_next(le_uflow_cnt_q, op_en_start, acc, lane_cnt(dp2lut_Xinfo, 16));
    le_oflow_cnt_d = cnt_next(le_oflow_cnt_q, op_en_start, acc, lane_cnt(dp2lut_Xinfo, 17));
    lo_uflow_cnt_d = cnt_next(lo_uflow_cnt_q, op_en_start, acc, lane_cnt(dp2lut_Yinfo, 16));
    lo_oflow_cnt_d = cnt_next(lo_oflow_cnt_q, op_en_start, acc, lane_cnt(dp2lut_Yinfo, 17));
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      vld_p1_q       <= 1'b0;
      x_data0_p1_q   <= '0;
      x_data1_p1_q   <= '0;
      y_data0_p1_q   <= '0;
      y_data1_p1_q   <= '0;
      xinfo_p1_q     <= '0;
      yinfo_p1_q     <= '0;
      le_uflow_cnt_q <= '0;
      le_oflow_cnt_q <= '0;
      lo_uflow_cnt_q <= '0;
      lo_oflow_cnt_q <= '0;
    end else begin
      vld_p1_q       <= vld_p1_d;
      x_data0_p1_q   <= x_data0_p1_d;
      x_data1_p1_q   <= x_data1_p1_d;
      y_data0_p1_q   <= y_data0_p1_d;
      y_data1_p1_q   <= y_data1_p1_d;
      xinfo_p1_q     <= xinfo_p1_d;
      yinfo_p1_q     <= yinfo_p1_d;
      le_uflow_cnt_q <= le_uflow_cnt_d;
      le_oflow_cnt_q <= le_oflow_cnt_d;
      lo_uflow_cnt_q <= lo_uflow_cnt_d;
      lo_oflow_cnt_q <= lo_oflow_cnt_d;
    end
  end

  assign lut2intp_pvld    = vld_p1_q;
  assign lut2intp_X_data0 = x_data0_p1_q;
  assign lut2intp_X_data1 = x_data1_p1_q;
  assign lut2intp_Y_data0 = y_data0_p1_q;
  assign lut2intp_Y_data1 = y_data1_p1_q;
  assign lut2intp_Xinfo   = xinfo_p1_q;
  assign lut2intp_Yinfo   = yinfo_p1_q;
  assign le_uflow_cnt     = le_uflow_cnt_q;
  assign le_oflow_cnt     = le_oflow_cnt_q;
  assign lo_uflow_cnt     = lo_uflow_cnt_q;
  assign lo_oflow_cnt     = lo_oflow_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_cdp_dp_lut_rd.sv
// Bench for the CDP LUT read stage: transaction-level table/counter model with an
// in-order expected-beat queue, directed corner cases and a randomized flow phase.
module tb_nv_nvdla_cdp_dp_lut_rd;

  localparam int TP   = 4;
  localparam int LE_D = 65;
  localparam int LO_D = 257;

  logic          clk = 1'b0;
  logic          rst;
  logic          dp2lut_pvld, dp2lut_prdy;
  logic [TP*10-1:0] dp2lut_X_entry, dp2lut_Y_entry;
  logic [TP*18-1:0] dp2lut_Xinfo, dp2lut_Yinfo;
  logic          lut2intp_pvld, lut2intp_prdy;
  logic [TP*16-1:0] x0, x1, y0, y1;
  logic [TP*18-1:0] xi, yi;
  logic          lut_wr_en, lut_wr_table;
  logic [8:0]    lut_wr_addr;
  logic [15:0]   lut_wr_data;
  logic          op_en_start;
  logic [31:0]   le_u, le_o, lo_u, lo_o;

  always #5 clk = ~clk;

  nv_nvdla_cdp_dp_lut_rd #(.TP(TP), .LE_DEPTH(LE_D), .LO_DEPTH(LO_D), .DATA_W(16)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .dp2lut_pvld(dp2lut_pvld), .dp2lut_prdy(dp2lut_prdy),
    .dp2lut_X_entry(dp2lut_X_entry), .dp2lut_Xinfo(dp2lut_Xinfo),
    .dp2lut_Y_entry(dp2lut_Y_entry), .dp2lut_Yinfo(dp2lut_Yinfo),
    .lut2intp_pvld(lut2intp_pvld), .lut2intp_prdy(lut2intp_prdy),
    .lut2intp_X_data0(x0), .lut2intp_X_data1(x1),
    .lut2intp_Y_data0(y0), .lut2intp_Y_data1(y1),
    .lut2intp_Xinfo(xi), .lut2intp_Yinfo(yi),
    .lut_wr_en(lut_wr_en), .lut_wr_table(lut_wr_table),
    .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .op_en_start(op_en_start),
    .le_uflow_cnt(le_u), .le_oflow_cnt(le_o), .lo_uflow_cnt(lo_u), .lo_oflow_cnt(lo_o)
  );

  typedef struct {
    logic [TP*16-1:0] x0, x1, y0, y1;
    logic [TP*18-1:0] xi, yi;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       snap;
  bit          stalled = 1'b0;
  bit          last_acc;
  logic [15:0] le_m [LE_D];
  logic [15:0] lo_m [LO_D];
  logic [31:0] mcnt [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic beat_t model_read();
    beat_t b;
    for (int m = 0; m < TP; m++) begin
      int ix, iy;
      ix = min_i(int'(dp2lut_X_entry[10*m +: 10]), LE_D - 1);
      iy = min_i(int'(dp2lut_Y_entry[10*m +: 10]), LO_D - 1);
      b.x0[16*m +: 16] = le_m[ix];
      b.x1[16*m +: 16] = le_m[min_i(ix + 1, LE_D - 1)];
      b.y0[16*m +: 16] = lo_m[iy];
      b.y1[16*m +: 16] = lo_m[min_i(iy + 1, LO_D - 1)];
    end
    b.xi = dp2lut_Xinfo;
    b.yi = dp2lut_Yinfo;
    return b;
  endfunction

  function automatic int lanes_set(input logic [TP*18-1:0] info, input int bitpos);
    int n = 0;
    for (int m = 0; m < TP; m++) if (info[18*m + bitpos]) n++;
    return n;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] base, input int n);
    longint t;
    t = longint'(base) + longint'(n);
    return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(t);
  endfunction

  // One clock: inputs were set at the falling edge; check, update model, advance.
  task automatic tick();
    bit pend, acc;
    beat_t e;
    #1;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = 32'h0;
      stalled  = 1'b0;
      last_acc = 1'b0;
    end else begin
      pend = (exp_q.size() != 0);
      chk("in_prdy", dp2lut_prdy, !pend || lut2intp_prdy);
      chk("out_pvld", lut2intp_pvld, pend);
      if (stalled) begin
        chk("hold_x0", x0, snap.x0); chk("hold_x1", x1, snap.x1);
        chk("hold_y0", y0, snap.y0); chk("hold_y1", y1, snap.y1);
        chk("hold_xi", xi, snap.xi); chk("hold_yi", yi, snap.yi);
      end
      if (pend && lut2intp_prdy) begin
        e = exp_q.pop_front();
        chk("x_data0", x0, e.x0); chk("x_data1", x1, e.x1);
        chk("y_data0", y0, e.y0); chk("y_data1", y1, e.y1);
        chk("xinfo", xi, e.xi);   chk("yinfo", yi, e.yi);
      end
      stalled = pend && !lut2intp_prdy;
      snap    = '{x0: x0, x1: x1, y0: y0, y1: y1, xi: xi, yi: yi};
      acc     = dp2lut_pvld && (!pend || lut2intp_prdy);
      last_acc = acc;
      if (acc) exp_q.push_back(model_read());
      if (op_en_start) for (int k = 0; k < 4; k++) mcnt[k] = 32'h0;
      if (acc) begin
        mcnt[0] = sat(mcnt[0], lanes_set(dp2lut_Xinfo, 16));
        mcnt[1] = sat(mcnt[1], lanes_set(dp2lut_Xinfo, 17));
        mcnt[2] = sat(mcnt[2], lanes_set(dp2lut_Yinfo, 16));
        mcnt[3] = sat(mcnt[3], lanes_set(dp2lut_Yinfo, 17));
      end
      if (lut_wr_en) begin
        if (!lut_wr_table && int'(lut_wr_addr) < LE_D) le_m[lut_wr_addr] = lut_wr_data;
        if ( lut_wr_table && int'(lut_wr_addr) < LO_D) lo_m[lut_wr_addr] = lut_wr_data;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("le_uflow_cnt", le_u, mcnt[0]);
    chk("le_oflow_cnt", le_o, mcnt[1]);
    chk("lo_uflow_cnt", lo_u, mcnt[2]);
    chk("lo_oflow_cnt", lo_o, mcnt[3]);
  endtask

  task automatic set_beat(input int xe, input int ye, input logic [17:0] xf, input logic [17:0] yf);
    for (int m = 0; m < TP; m++) begin
      dp2lut_X_entry[10*m +: 10] = 10'(xe);
      dp2lut_Y_entry[10*m +: 10] = 10'(ye);
      dp2lut_Xinfo[18*m +: 18]   = xf;
      dp2lut_Yinfo[18*m +: 18]   = yf;
    end
  endtask

  task automatic rand_beat();
    logic [31:0] r;
    for (int m = 0; m < TP; m++) begin
      dp2lut_X_entry[10*m +: 10] = 10'($urandom_range(0, 1023));
      dp2lut_Y_entry[10*m +: 10] = 10'($urandom_range(0, 1023));
      r = $urandom(); dp2lut_Xinfo[18*m +: 18] = r[17:0];
      r = $urandom(); dp2lut_Yinfo[18*m +: 18] = r[17:0];
    end
  endtask

  task automatic wr(input logic tbl, input int addr, input logic [15:0] data);
    lut_wr_en = 1'b1; lut_wr_table = tbl; lut_wr_addr = 9'(addr); lut_wr_data = data;
    tick();
    lut_wr_en = 1'b0;
  endtask

  task automatic lanes_eq(input string tag, input logic [TP*16-1:0] v, input logic [15:0] exp);
    for (int m = 0; m < TP; m++) chk(tag, v[16*m +: 16], exp);
  endtask

  initial begin
    int accepted, cycles;
    logic [TP*18-1:0] inf;
    rst = 1'b1; dp2lut_pvld = 1'b0; lut2intp_prdy = 1'b1;
    dp2lut_X_entry = '0; dp2lut_Y_entry = '0; dp2lut_Xinfo = '0; dp2lut_Yinfo = '0;
    lut_wr_en = 1'b0; lut_wr_table = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
    op_en_start = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_pvld", lut2intp_pvld, 1'b0);
    chk("rst_prdy", dp2lut_prdy, 1'b1);
    chk("rst_x0", x0, '0); chk("rst_y1", y1, '0); chk("rst_xi", xi, '0);
    rst = 1'b0;

    for (int k = 0; k < LE_D; k++) wr(1'b0, k, 16'(16'h100 + k));
    for (int k = 0; k < LO_D; k++) wr(1'b1, k, 16'(16'h2000 + k));

    // Basic pair read
    set_beat(5, 200, 18'h0, 18'h0); dp2lut_pvld = 1'b1; tick(); dp2lut_pvld = 1'b0;
    chk("basic_pvld", lut2intp_pvld, 1'b1);
    lanes_eq("basic_x0", x0, 16'h105); lanes_eq("basic_x1", x1, 16'h106);
    lanes_eq("basic_y0", y0, 16'h20C8); lanes_eq("basic_y1", y1, 16'h20C9);
    tick();

    // Top-of-table and clamped indices
    set_beat(64, 256, 18'h0, 18'h0); dp2lut_pvld = 1'b1; tick();
    lanes_eq("edge_x0", x0, 16'h140); lanes_eq("edge_x1", x1, 16'h140);
    lanes_eq("edge_y0", y0, 16'h2100); lanes_eq("edge_y1", y1, 16'h2100);
    set_beat(900, 1000, 18'h0, 18'h0); tick(); dp2lut_pvld = 1'b0;
    lanes_eq("clamp_x0", x0, 16'h140); lanes_eq("clamp_x1", x1, 16'h140);
    lanes_eq("clamp_y0", y0, 16'h2100); lanes_eq("clamp_y1", y1, 16'h2100);
    tick();

    // Backpressure
    lut2intp_prdy = 1'b0;
    set_beat(10, 20, 18'h1234, 18'h4321); dp2lut_pvld = 1'b1; tick();
    set_beat(11, 21, 18'h0ABC, 18'h0CBA);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_in_prdy", dp2lut_prdy, 1'b0);
      lanes_eq("bp_x0", x0, 16'h10A);
    end
    lut2intp_prdy = 1'b1; tick(); dp2lut_pvld = 1'b0;
    lanes_eq("bp_next_x0", x0, 16'h10B);
    tick();

    // Write/read collision on the same entry
    set_beat(5, 0, 18'h0, 18'h0); dp2lut_pvld = 1'b1;
    lut_wr_en = 1'b1; lut_wr_table = 1'b0; lut_wr_addr = 9'd5; lut_wr_data = 16'hBEEF;
    tick(); lut_wr_en = 1'b0;
    lanes_eq("coll_old", x0, 16'h105);
    tick(); dp2lut_pvld = 1'b0;
    lanes_eq("coll_new", x0, 16'hBEEF);
    tick();
    wr(1'b0, 100, 16'hDEAD);
    wr(1'b1, 300, 16'hDEAD);
    dp2lut_pvld = 1'b1;
    for (int b = 0; b < 17; b++) begin
      for (int m = 0; m < TP; m++) begin
        dp2lut_X_entry[10*m +: 10] = 10'(4*b + m);
        dp2lut_Y_entry[10*m +: 10] = 10'(240 + 4*b + m);
      end
      tick();
    end
    dp2lut_pvld = 1'b0; tick();

    // Counters: count, saturate, clear-then-count
    op_en_start = 1'b1; tick(); op_en_start = 1'b0;
    inf = '0; for (int m = 0; m < 3; m++) inf[18*m + 16] = 1'b1;
    set_beat(1, 1, 18'h0, 18'h0); dp2lut_Xinfo = inf; dp2lut_pvld = 1'b1; tick(); dp2lut_pvld = 1'b0;
    chk("cnt3", le_u, 32'd3);
    tick();
    force dut.le_uflow_cnt_q = 32'hFFFF_FFFE;
    mcnt[0] = 32'hFFFF_FFFE;
    tick();
    release dut.le_uflow_cnt_q;
    dp2lut_Xinfo = inf; dp2lut_pvld = 1'b1; tick(); dp2lut_pvld = 1'b0;
    chk("cnt_sat", le_u, 32'hFFFF_FFFF);
    inf = '0; inf[17] = 1'b1; inf[18*2 + 17] = 1'b1;
    dp2lut_Xinfo = inf; op_en_start = 1'b1; dp2lut_pvld = 1'b1; tick();
    op_en_start = 1'b0; dp2lut_pvld = 1'b0;
    chk("clr_cnt_o", le_o, 32'd2);
    chk("clr_cnt_u", le_u, 32'd0);
    tick();

    // Reset with a beat pending at the output
    lut2intp_prdy = 1'b0;
    set_beat(7, 7, 18'h3FFFF, 18'h3FFFF); dp2lut_pvld = 1'b1; tick(); dp2lut_pvld = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_pvld", lut2intp_pvld, 1'b0);
    chk("mid_rst_prdy", dp2lut_prdy, 1'b1);
    chk("mid_rst_cnt", le_u, 32'd0);
    chk("mid_rst_x0", x0, '0);
    lut2intp_prdy = 1'b1; tick();

    // Random flow with random ready, writes and layer starts
    accepted = 0; cycles = 0;
    rand_beat();
    while (accepted < 100 && cycles < 3000) begin
      if (!dp2lut_pvld) dp2lut_pvld = ($urandom_range(0, 3) != 0);
      lut2intp_prdy = ($urandom_range(0, 2) != 0);
      op_en_start   = ($urandom_range(0, 19) == 0);
      lut_wr_en     = ($urandom_range(0, 4) == 0);
      lut_wr_table  = $urandom_range(0, 1);
      lut_wr_addr   = 9'($urandom_range(0, 300));
      lut_wr_data   = 16'($urandom());
      tick();
      cycles++;
      if (last_acc) begin
        accepted++;
        dp2lut_pvld = 1'b0;
        rand_beat();
      end
    end
    dp2lut_pvld = 1'b0; lut_wr_en = 1'b0; op_en_start = 1'b0; lut2intp_prdy = 1'b1;
    tick(); tick();
    chk("rand_accepted", 72'(accepted), 72'd100);
    chk("rand_drained", 72'(exp_q.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
